// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one valid/ready memory port between the icache miss
// port (instr side, read only) and the core load/store port (data side).
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_valid/i_ready/i_addr/i_rdata  instr requester
//   d_valid/d_ready/d_addr/d_wdata/d_wstrb/d_rdata  data requester
//   mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata  memory side
//   mem_instr                       high while the instr side holds the grant
//
// Parameters:
//   DPRIO  1: data side wins every conflict; 0: round-robin on conflict
//
// The grant is registered; request fields are muxed straight through and
// not captured, so requesters hold them stable while valid.

module mem_arbiter #(
  parameter bit DPRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,

  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,

  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        mem_instr
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;
  // 1 = the last completed grant went to the data side
  logic       last_q;
  logic       last_d;

  logic       gnt_i;
  logic       gnt_d;
  logic       win_d;

  assign gnt_i = (state_q == GNT_I);
  assign gnt_d = (state_q == GNT_D);

  // Conflict winner: fixed data priority, or the side not served last.
  assign win_d = DPRIO || !last_q;

  // Memory request path depends only on the grant and the granted
  // requester's valid, never on mem_ready.
  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    unique case (1'b1)
      gnt_i: begin
        mem_valid = i_valid;
        mem_addr  = i_addr;
      end
      gnt_d: begin
        mem_valid = d_valid;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_wstrb = d_wstrb;
      end
      default: ;
    endcase
  end

  assign mem_instr = gnt_i;

  assign i_ready = gnt_i & mem_valid & mem_ready;
  assign d_ready = gnt_d & mem_valid & mem_ready;

  assign i_rdata = gnt_i ? mem_rdata : 32'h0;
  assign d_rdata = gnt_d ? mem_rdata : 32'h0;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid && d_valid) begin
          state_d = win_d ? GNT_D : GNT_I;
        end else if (i_valid) begin
          state_d = GNT_I;
        end else if (d_valid) begin
          state_d = GNT_D;
        end
      end
      GNT_I: begin
        // A dropped request is abandoned without touching fairness.
        if (!i_valid) begin
          state_d = IDLE;
        end else if (mem_ready) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      GNT_D: begin
        if (!d_valid) begin
          state_d = IDLE;
        end else if (mem_ready) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule
